// File: rtl/seq_shifter_pkg.sv
// rtl/seq_shifter_pkg.sv - shared width, op encodings and FSM states for seq_shifter
package seq_shifter_pkg;

    localparam int WIDTH = 16;

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// rtl/seq_shifter_shift_step.sv - combinational one-position shift/rotate of a 16-bit word
module shift_step
    import seq_shifter_pkg::*;
(
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            OP_ROR:  dout = {din[0], din[WIDTH-1:1]};
            OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
            // sign taken from the value entering this step so it keeps propagating
            OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
            OP_ROL:  dout = {din[WIDTH-2:0], din[WIDTH-1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle 16-bit shift/rotate unit with start/done handshake
// Optional two-positions-per-cycle stepping under SEQ_SHIFTER_RADIX4_EN.
module seq_shifter
    import seq_shifter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic [3:0]       Cnt,
    input  logic [1:0]       Op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out
);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [3:0]       rem;
    logic [1:0]       op_q;

    logic [WIDTH-1:0] step1;
    logic [WIDTH-1:0] next_work;
    logic [3:0]       dec;
    logic [3:0]       rem_next;

    shift_step u_step1 (
        .din  (work),
        .op   (op_q),
        .dout (step1)
    );

`ifdef SEQ_SHIFTER_RADIX4_EN
    logic [WIDTH-1:0] step2;

    shift_step u_step2 (
        .din  (step1),
        .op   (op_q),
        .dout (step2)
    );

    // a single remaining position must not be over-shifted by the second stage
    assign next_work = (rem >= 4'd2) ? step2 : step1;
    assign dec       = (rem >= 4'd2) ? 4'd2 : 4'd1;
`else
    assign next_work = step1;
    assign dec       = 4'd1;
`endif

    assign rem_next = rem - dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            work  <= '0;
            rem   <= '0;
            op_q  <= OP_ROR;
        end else begin
            case (state)
                ST_SHIFT: begin
                    work <= next_work;
                    rem  <= rem_next;
                    if (rem_next == 4'd0)
                        state <= ST_DONE;
                end
                default: begin
                    if (start) begin
                        work  <= In;
                        rem   <= Cnt;
                        op_q  <= Op;
                        state <= (Cnt == 4'd0) ? ST_DONE : ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);
    assign Out  = work;

endmodule
